// File: rtl/hack_mem_pkg.sv
// Shared memory-map constants, region decode and screen-write entry format
// for the Hack data-memory stage.
package hack_mem_pkg;

  localparam logic [15:0] RAM_BASE     = 16'h0000;
  localparam logic [15:0] SCREEN_BASE  = 16'h4000;
  localparam logic [15:0] SCREEN_LIMIT = 16'h5FFF;
  localparam logic [15:0] KBD_ADDR     = 16'h6000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_UNMAPPED
  } region_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_entry_t;

  // RAM occupies everything below the screen base, so RAM_BASE is implicit.
  function automatic region_t decode_region(input logic [15:0] a);
    region_t r;
    if (a < SCREEN_BASE)        r = REG_RAM;
    else if (a <= SCREEN_LIMIT) r = REG_SCREEN;
    else if (a == KBD_ADDR)     r = REG_KBD;
    else                        r = REG_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// Single-clock FIFO with occupancy counter; no fall-through, head is read
// straight from storage so it stays stable until popped.
module hack_sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is still taken when the head leaves this cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, readable screen shadow, keyboard register, and a
// queue forwarding every screen write to the display controller.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int OVF_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      addressM,
  input  logic [15:0]      outM,
  input  logic             writeM,
  output logic [15:0]      inM,
  output logic             scr_valid,
  input  logic             scr_ready,
  output logic [12:0]      scr_addr,
  output logic [15:0]      scr_data,
  input  logic             kbd_valid,
  input  logic [15:0]      kbd_code,
  output logic [OVF_W-1:0] ovf_count,
  output logic             bad_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0] ram    [16384];
  logic [15:0] screen [8192];
  logic [15:0] kbd_reg;

  region_t    region;
  scr_entry_t push_entry, head;
  logic       scr_push, scr_pop, drop;
  logic       fifo_full, fifo_empty;
  logic [AW:0] unused_fifo_count;

  assign region = decode_region(addressM);

  always_comb begin
    inM = 16'h0000;
    case (region)
      REG_RAM:    inM = ram[addressM[13:0]];
      REG_SCREEN: inM = screen[addressM[12:0]];
      REG_KBD:    inM = kbd_reg;
      default:    inM = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (writeM && region == REG_RAM)    ram[addressM[13:0]]    <= outM;
    if (writeM && region == REG_SCREEN) screen[addressM[12:0]] <= outM;
  end

  assign scr_push   = writeM && (region == REG_SCREEN);
  assign scr_pop    = scr_valid & scr_ready;
  assign drop       = scr_push & fifo_full & ~scr_pop;
  assign push_entry = '{addr: addressM[12:0], data: outM};

  hack_sync_fifo #(
    .WIDTH ($bits(scr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_scr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (scr_push),
    .pop   (scr_pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  assign scr_valid = ~fifo_empty;
  assign scr_addr  = head.addr;
  assign scr_data  = head.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_reg   <= 16'h0000;
      ovf_count <= '0;
      bad_addr  <= 1'b0;
    end else begin
      if (kbd_valid) kbd_reg <= kbd_code;
      if (drop && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
      // Address 0 with writeM low is the CPU idling, not a read.
      if (region == REG_UNMAPPED && (writeM || addressM != 16'h0000))
        bad_addr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: memory map, screen queue, keyboard,
// sticky bad-address flag and asynchronous reset.
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM, outM;
  logic        writeM;
  logic [15:0] inM;
  logic        scr_valid, scr_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic [7:0]  ovf_count;
  logic        bad_addr;

  int vectors = 0;
  int miscompares = 0;

  hack_data_memory #(.FIFO_DEPTH(8), .OVF_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .inM       (inM),
    .scr_valid (scr_valid),
    .scr_ready (scr_ready),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data),
    .kbd_valid (kbd_valid),
    .kbd_code  (kbd_code),
    .ovf_count (ovf_count),
    .bad_addr  (bad_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scr_write(input logic [15:0] a, input logic [15:0] d);
    addressM = a; outM = d; writeM = 1'b1;
    tick();
    writeM = 1'b0; addressM = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; addressM = 16'h0000; outM = 16'h0000; writeM = 1'b0;
    scr_ready = 1'b0; kbd_valid = 1'b0; kbd_code = 16'h0000;
    #3;
    chk("rst_valid", 16'(scr_valid), 16'h0);
    chk("rst_ovf",   16'(ovf_count), 16'h0);
    chk("rst_bad",   16'(bad_addr),  16'h0);
    addressM = 16'h6000; #1;
    chk("rst_kbd", inM, 16'h0000);
    addressM = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    tick();

    // RAM write then read back
    addressM = 16'h0010; outM = 16'h1234; writeM = 1'b1;
    tick();
    writeM = 1'b0; #1;
    chk("ram_rd",    inM, 16'h1234);
    chk("ram_valid", 16'(scr_valid), 16'h0);
    chk("ram_ovf",   16'(ovf_count), 16'h0);

    // Single screen write held against backpressure
    scr_write(16'h4005, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 16'(scr_valid), 16'h1);
      chk("hold_addr",  16'(scr_addr),  16'h0005);
      chk("hold_data",  scr_data,       16'hFFFF);
      tick();
    end
    scr_ready = 1'b1;
    tick();
    scr_ready = 1'b0;
    chk("pop_valid", 16'(scr_valid), 16'h0);
    addressM = 16'h4005; #1;
    chk("shadow_rd", inM, 16'hFFFF);
    addressM = 16'h0000;

    // Ten writes into an 8-deep queue: two dropped
    for (int i = 0; i < 10; i++) scr_write(16'h4000 + 16'(i), 16'hA000 + 16'(i));
    chk("ovf_two", 16'(ovf_count), 16'h0002);
    addressM = 16'h4009; #1;
    chk("shadow_dropped", inM, 16'hA009);
    addressM = 16'h0000;
    scr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 16'(scr_valid), 16'h1);
      chk("drain_addr",  16'(scr_addr),  16'(i));
      chk("drain_data",  scr_data,       16'hA000 + 16'(i));
      tick();
    end
    scr_ready = 1'b0;
    chk("drain_empty", 16'(scr_valid), 16'h0);

    // Full queue: simultaneous push and pop
    for (int i = 0; i < 8; i++) scr_write(16'h4100 + 16'(i), 16'hB000 + 16'(i));
    chk("full_ovf", 16'(ovf_count), 16'h0002);
    scr_ready = 1'b1;
    scr_write(16'h4200, 16'hC000);
    chk("pp_ovf", 16'(ovf_count), 16'h0002);
    for (int i = 1; i < 8; i++) begin
      chk("pp_addr", 16'(scr_addr), 16'h0100 + 16'(i));
      chk("pp_data", scr_data,      16'hB000 + 16'(i));
      tick();
    end
    chk("pp_last_valid", 16'(scr_valid), 16'h1);
    chk("pp_last_addr",  16'(scr_addr),  16'h0200);
    chk("pp_last_data",  scr_data,       16'hC000);
    tick();
    scr_ready = 1'b0;
    chk("pp_empty", 16'(scr_valid), 16'h0);

    // Keyboard register
    kbd_valid = 1'b1; kbd_code = 16'h0083;
    tick();
    kbd_valid = 1'b0; kbd_code = 16'h1111;
    addressM = 16'h6000; #1;
    chk("kbd_load", inM, 16'h0083);
    tick();
    chk("kbd_hold", inM, 16'h0083);
    outM = 16'h5555; writeM = 1'b1;
    tick();
    writeM = 1'b0;
    chk("kbd_wr_ign", inM, 16'h0083);
    kbd_valid = 1'b1; kbd_code = 16'h0000;
    tick();
    kbd_valid = 1'b0;
    chk("kbd_release", inM, 16'h0000);
    chk("kbd_no_bad", 16'(bad_addr), 16'h0);

    // Unmapped read sets sticky flag
    addressM = 16'h6001; #1;
    chk("unmap_rd", inM, 16'h0000);
    tick();
    addressM = 16'h0000;
    tick();
    chk("bad_sticky", 16'(bad_addr), 16'h1);

    // Asynchronous reset mid-drain with 3 entries queued
    kbd_valid = 1'b1; kbd_code = 16'h0041;
    tick();
    kbd_valid = 1'b0;
    for (int i = 0; i < 3; i++) scr_write(16'h4300 + 16'(i), 16'hD000 + 16'(i));
    chk("pre_rst_valid", 16'(scr_valid), 16'h1);
    addressM = 16'h6000;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 16'(scr_valid), 16'h0);
    chk("arst_ovf",   16'(ovf_count), 16'h0);
    chk("arst_bad",   16'(bad_addr),  16'h0);
    chk("arst_kbd",   inM,            16'h0000);
    tick();
    reset = 1'b0;
    addressM = 16'h0000;
    tick();
    chk("post_rst_valid", 16'(scr_valid), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory stage directly downstream of the Hack CPU core; consumes the CPU's registered `addressM`, `outM` and `writeM`, and returns `inM`.
- Implements the Hack memory map:
  - general RAM, 16K words;
  - screen region, 8K words, readable shadow copy;
  - keyboard register, 1 word.
- Every screen write is also queued in a small FIFO and drained to the display controller over a valid/ready interface.

Parameters:
- FIFO_DEPTH, 8, screen-write FIFO entries; power of two, ≥2.
- OVF_W, 8, width of the saturating FIFO-overflow counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addressM  in  16  word address from CPU
- outM  in  16  write data from CPU
- writeM  in  1  write enable from CPU
- inM  out  16  read data to CPU, combinational from addressM
- scr_valid  out  1  FIFO head valid
- scr_ready  in  1  display controller accepts head
- scr_addr  out  13  screen word offset (addressM − 0x4000)
- scr_data  out  16  screen pixel word
- kbd_valid  in  1  one-cycle strobe: new key code present
- kbd_code  in  16  key code; 0 means key released
- ovf_count  out  OVF_W  saturating count of dropped screen pushes
- bad_addr  out  1  sticky flag: access to an unmapped address

Behaviour:
- Address decode on addressM:
  - 0x0000–0x3FFF: RAM;
  - 0x4000–0x5FFF: SCREEN;
  - 0x6000: KBD;
  - everything else, including bit15=1: UNMAPPED.
- Reads (combinational, zero latency):
  - inM = RAM[a], SCREEN[a−0x4000], or kbd_reg, according to region;
  - UNMAPPED reads return 0x0000.
- Writes (on posedge clk when writeM=1):
  - RAM region: RAM[a] ← outM; visible on inM the following cycle.
  - SCREEN region: shadow updated, and {a[12:0], outM} is pushed to the FIFO.
  - KBD region: write ignored.
  - UNMAPPED: write ignored.
- bad_addr:
  - set on any clock edge where the decoded region is UNMAPPED and writeM=1;
  - also set when an UNMAPPED read is seen. Since reads are continuous, a "read" is defined as writeM=0 with addressM ≠ 0.
  - Cleared only by reset.
- RAM and screen-shadow contents are not reset (power-up undefined); the bench must initialise them before reading.
- kbd_reg:
  - loads kbd_code on any cycle with kbd_valid=1;
  - holds its value otherwise;
  - reset value 0x0000. A code of 0 represents key release.
- FIFO (sub-module):
  - push = screen write; pop = scr_valid & scr_ready.
  - scr_valid=1 whenever the FIFO is non-empty; scr_addr/scr_data always present the head entry.
  - Head data must stay stable while scr_valid=1 and scr_ready=0.
  - Push into a non-full FIFO: accepted; the entry is visible at the head on the next cycle if the FIFO was empty (1-cycle latency, no fall-through).
  - Push when full with a pop in the same cycle: accepted, count unchanged.
  - Push when full with no pop: dropped, ovf_count increments and saturates at 2^OVF_W−1. The shadow RAM is still written.
  - Pop when empty: impossible, because scr_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy count.
- Reset, applied asynchronously at any time including mid-drain:
  - FIFO emptied; scr_valid=0 immediately;
  - kbd_reg=0, ovf_count=0, bad_addr=0.
  - Pending entries are lost; no partial handshake survives.

Decomposition:
- Shared package hack_mem_pkg:
  - region base/limit constants: RAM_BASE, SCREEN_BASE, SCREEN_LIMIT, KBD_ADDR;
  - region enum {REG_RAM, REG_SCREEN, REG_KBD, REG_UNMAPPED};
  - screen entry struct {addr[12:0], data[15:0]}.
- One sub-module: hack_sync_fifo, parameterised by width and depth, with push/pop/full/empty/count.
- Decode and RAM arrays stay in the top module.

Test Plan:
- Write 0x1234 to 0x0010, then read 0x0010 → inM=0x1234 on the cycle after the write; ovf_count=0 and scr_valid=0 throughout.
- Write 0xFFFF to 0x4005 with scr_ready=0 → scr_valid=1 next cycle, scr_addr=0x0005, scr_data=0xFFFF held stable for 5 cycles; then scr_ready=1 → pop, scr_valid=0; read 0x4005 returns 0xFFFF.
- Ten consecutive screen writes with scr_ready=0 (FIFO_DEPTH=8) → 8 entries queued in order, ovf_count=2; drain → 8 pops with matching addr/data, in order.
- FIFO full, then push and pop in the same cycle → push accepted, ovf_count unchanged, occupancy stays 8, new entry emerges last.
- kbd_valid strobe with code 0x0083 → reading 0x6000 gives 0x0083 until a strobe with 0 arrives, then 0x0000; writing 0x5555 to 0x6000 leaves the value unchanged.
- Read 0x6001 → inM=0x0000 and bad_addr=1. Then assert reset mid-drain with 3 entries queued → scr_valid=0, ovf_count=0, bad_addr=0 and kbd_reg=0 immediately, without waiting for a clock edge.
